program_loader: RTL and testbench
=================================

# program_loader

Boot-time sequencer that sits in front of the single-cycle processor and its instruction memory. It accepts a byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. It writes those words to consecutive instruction-memory addresses starting at 0. It holds the processor in reset until the load completes, then releases it for a fixed number of cycles' delay and reports run state.

## Interface
- ADDR_WIDTH, 10, instruction-memory word-address width; depth = 2^ADDR_WIDTH words.
- RST_HOLD, 2, cycles `proc_rst` stays high in RELEASE after the last word is written (≥1).

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  load request; acted on only in IDLE or RUN.
- word_count  in  ADDR_WIDTH+1  words to load; sampled when `start` is accepted.
- byte_data  in  8  stream byte.
- byte_valid  in  1  `byte_data` valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_WIDTH  word address.
- imem_wdata  out  32  word to write.
- proc_rst  out  1  processor reset; high except in RUN.
- busy  out  1  high in LOAD, COMMIT, RELEASE.
- done  out  1  high in RUN.
- error  out  1  sticky bad-`start` flag.

## Operation
- States: IDLE, LOAD, COMMIT, RELEASE, RUN.
- Moore outputs decoded from state:
  - `byte_ready` = LOAD.
  - `imem_we` = COMMIT.
  - `proc_rst` = not RUN.
  - `done` = RUN.
  - `busy` = LOAD | COMMIT | RELEASE.
- IDLE / RUN:
  - `start` with 1 ≤ `word_count` ≤ 2^ADDR_WIDTH → LOAD. Latch the count, clear the word index, byte index and `error`.
  - `start` with a `word_count` of 0 or greater than the depth → set `error`, state unchanged. A RUN processor keeps running.
- LOAD:
  - A byte is accepted when `byte_valid` & `byte_ready`.
  - Byte index k (0..3) goes to `imem_wdata[8k+7:8k]`, so the first byte is the LSB.
  - Accepting byte 3 → COMMIT. Byte index wraps to 0.
- COMMIT: one cycle of `imem_we` with `imem_addr` = word index.
  - If word index = count−1 → RELEASE and clear the hold counter.
  - Otherwise increment the word index → LOAD.
- RELEASE: counts RST_HOLD cycles, then → RUN.
- RUN: holds until `start` or `rst`.
- `byte_valid` while `byte_ready` is low is ignored. The loader never buffers more than the word under assembly.
- `imem_addr` and `imem_wdata` keep their last value outside COMMIT.

## Timing
- Reset values, at the first edge with `rst` high:
  - state IDLE.
  - `proc_rst`=1.
  - `byte_ready`, `imem_we`, `busy`, `done`, `error` all 0.
  - `imem_addr`=0, `imem_wdata`=0; all counters 0.
- `rst` mid-load:
  - The partial word is discarded.
  - Words already written are not undone.
  - The processor stays in reset.
- `start` is accepted on edge t. `byte_ready`=1 and `busy`=1 from t+1, and `proc_rst` rises at t+1 when leaving RUN.
- Per word: at least 4 accept cycles plus 1 COMMIT cycle; `byte_ready`=0 during COMMIT.
- Minimum load time for N words: 5N + RST_HOLD cycles from the first accepted byte to `done`=1.
- `proc_rst` falls on the same edge `done` rises.
- `start` during LOAD, COMMIT or RELEASE is ignored and does not set `error`.
- The `word_count` maximum (2^ADDR_WIDTH) writes the last address, all ones. There is no address wrap.

## Structure
- Package `program_loader_pkg` holds:
  - `loader_state_t` enum for the five states.
  - Byte-per-word constant 4.
  - Default ADDR_WIDTH and RST_HOLD.
- Sub-module `byte_packer`:
  - Owns the 2-bit byte index and the 32-bit shift/assembly register.
  - Takes `accept` and `clear`.
  - Outputs `word`, plus `last_byte` (high when index = 3).
- The top level holds the FSM, the word/hold counters and the output decode.

## Test plan
- Load 2 words with bytes 0a 00 a0 e3 00 10 a0 e1 and `byte_valid` held high. Required response:
  - Writes addr0=0xe3a0000a, then addr1=0xe1a01000.
  - `proc_rst` falls exactly 2 cycles after the second `imem_we`.
  - `done`=1 on the same edge.
- Same 2-word load with `byte_valid` toggled every other cycle → identical writes. No byte is lost or duplicated.
- `start` with `word_count`=0 → `error`=1, state stays IDLE, `busy`=0. A following valid `start` clears `error`.
- Assert `rst` after 6 bytes of a 3-word load:
  - Addr0 has been written; no write to addr1 occurs.
  - All outputs return to reset values on the next edge.
- In RUN, `start` with `word_count`=1 and bytes 1e 50 43 e2:
  - `proc_rst` rises the next cycle.
  - Addr0=0xe243501e is written.
  - RUN is re-entered.
- Load with ADDR_WIDTH=2 and `word_count`=4 → the final write is to addr 3. A `word_count` of 5 sets `error`.

Source files
------------

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// program_loader_pkg : state encoding and defaults for the boot loader
// Rev 1.0
// ------------------------------------------------------------------------
package program_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_RST_HOLD   = 2;
  localparam int BYTES_PER_WORD     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMMIT  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } loader_state_t;

  // Width of a counter that must reach hold-1; never narrower than one bit.
  function automatic int hold_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_byte_packer.sv
`default_nettype none
// ------------------------------------------------------------------------
// byte_packer : assembles four stream bytes into a little-endian word
// Rev 1.0
// ------------------------------------------------------------------------
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        accept,
  input  logic        clear,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        last_byte
);

  logic [1:0]  r_idx;
  logic [31:0] r_word;

  // Shifting in at the top leaves the first byte in the LSB after four accepts.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_idx  <= 2'd0;
      r_word <= 32'd0;
    end else if (accept) begin
      r_idx  <= r_idx + 2'd1;
      r_word <= {data, r_word[31:8]};
    end
  end

  assign word      = r_word;
  assign last_byte = (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ------------------------------------------------------------------------
// program_loader : loads a byte stream into instruction memory, then
//                  releases the processor from reset
// Rev 1.0
// ------------------------------------------------------------------------
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int RST_HOLD   = DEFAULT_RST_HOLD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  proc_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int                     C_HOLD_W    = hold_width(RST_HOLD);
  localparam logic [ADDR_WIDTH:0]    C_DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]    C_CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0]  C_IDX_ONE   = ADDR_WIDTH'(1);
  localparam logic [C_HOLD_W-1:0]    C_HOLD_ONE  = C_HOLD_W'(1);
  localparam logic [C_HOLD_W-1:0]    C_HOLD_LAST = C_HOLD_W'(RST_HOLD - 1);

  loader_state_t          r_state;
  loader_state_t          w_next_state;
  logic [ADDR_WIDTH:0]    r_count;
  logic [ADDR_WIDTH-1:0]  r_word_idx;
  logic [C_HOLD_W-1:0]    r_hold;
  logic [ADDR_WIDTH-1:0]  r_imem_addr;
  logic [31:0]            r_imem_wdata;
  logic                   r_error;

  logic                   w_idle_or_run;
  logic                   w_count_ok;
  logic                   w_start_ok;
  logic                   w_start_bad;
  logic                   w_accept;
  logic                   w_last_byte;
  logic                   w_last_word;
  logic                   w_hold_done;
  logic [31:0]            w_packed;

  assign w_idle_or_run = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign w_count_ok    = (word_count != '0) && (word_count <= C_DEPTH);
  assign w_start_ok    = start && w_idle_or_run && w_count_ok;
  assign w_start_bad   = start && w_idle_or_run && !w_count_ok;
  assign w_accept      = byte_valid && (r_state == ST_LOAD);
  assign w_last_word   = ({1'b0, r_word_idx} == (r_count - C_CNT_ONE));
  assign w_hold_done   = (r_hold == C_HOLD_LAST);

  byte_packer u_byte_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (w_accept),
    .clear     (w_start_ok),
    .data      (byte_data),
    .word      (w_packed),
    .last_byte (w_last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_RUN: if (w_start_ok) w_next_state = ST_LOAD;
      ST_LOAD:         if (w_accept && w_last_byte) w_next_state = ST_COMMIT;
      ST_COMMIT:       w_next_state = w_last_word ? ST_RELEASE : ST_LOAD;
      ST_RELEASE:      if (w_hold_done) w_next_state = ST_RUN;
      default:         w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    proc_rst   = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      ST_COMMIT: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
      ST_RELEASE: busy = 1'b1;
      ST_RUN: begin
        proc_rst = 1'b0;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_word_idx   <= '0;
      r_hold       <= '0;
      r_imem_addr  <= '0;
      r_imem_wdata <= 32'd0;
      r_error      <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_count    <= word_count;
        r_word_idx <= '0;
        r_error    <= 1'b0;
      end else if (w_start_bad) begin
        r_error <= 1'b1;
      end

      // Capture the written word so the memory bus holds steady afterwards.
      if (r_state == ST_COMMIT) begin
        r_imem_addr  <= r_word_idx;
        r_imem_wdata <= w_packed;
        if (w_last_word) begin
          r_hold <= '0;
        end else begin
          r_word_idx <= r_word_idx + C_IDX_ONE;
        end
      end

      if ((r_state == ST_RELEASE) && !w_hold_done) begin
        r_hold <= r_hold + C_HOLD_ONE;
      end
    end
  end

  assign imem_addr  = (r_state == ST_COMMIT) ? r_word_idx : r_imem_addr;
  assign imem_wdata = (r_state == ST_COMMIT) ? w_packed   : r_imem_wdata;
  assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_program_loader : randomized self-checking bench for program_loader
// Rev 1.0
// ------------------------------------------------------------------------
module tb_program_loader;

  localparam int RST_HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: default 10-bit address DUT, index 1: 2-bit address DUT.
  logic [1:0]        st;
  logic [1:0]        bv;
  logic [1:0][10:0]  wcnt;
  logic [1:0][7:0]   bd;
  wire  [1:0]        br, we, prst, bsy, dn, err;
  wire  [1:0][31:0]  wd;
  wire  [9:0]        a0;
  wire  [1:0]        a1;

  program_loader #(.ADDR_WIDTH(10), .RST_HOLD(RST_HOLD)) u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]), .word_count(wcnt[0]),
    .byte_data(bd[0]), .byte_valid(bv[0]), .byte_ready(br[0]),
    .imem_we(we[0]), .imem_addr(a0), .imem_wdata(wd[0]),
    .proc_rst(prst[0]), .busy(bsy[0]), .done(dn[0]), .error(err[0])
  );

  program_loader #(.ADDR_WIDTH(2), .RST_HOLD(RST_HOLD)) u_dut1 (
    .clk(clk), .rst(rst), .start(st[1]), .word_count(wcnt[1][2:0]),
    .byte_data(bd[1]), .byte_valid(bv[1]), .byte_ready(br[1]),
    .imem_we(we[1]), .imem_addr(a1), .imem_wdata(wd[1]),
    .proc_rst(prst[1]), .busy(bsy[1]), .done(dn[1]), .error(err[1])
  );

  typedef struct {
    int          d;
    int          addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  inv_en  = 1'b0;
  wr_t wrs[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int get_addr(input int d);
    return (d == 0) ? int'(a0) : int'(a1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Write log plus the state-level invariants that hold in every cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (we[d] === 1'b1) wrs.push_back('{d, get_addr(d), wd[d], cyc});
      if (inv_en) begin
        check("prst_vs_done", prst[d], !dn[d]);
        check("we_with_ready", we[d] & br[d], 0);
      end
    end
  end

  task automatic do_start(input int d, input int n);
    @(negedge clk);
    st[d]   = 1'b1;
    wcnt[d] = 11'(n);
    @(negedge clk);
    st[d]   = 1'b0;
  endtask

  task automatic feed(input int d, input logic [7:0] bytes[$], input int mode,
                      input int limit, output int first_cyc);
    int idx = 0;
    int g   = 0;
    bit acc;
    bit ph  = 1'b0;
    first_cyc = -1;
    while (idx < limit && g < 4000) begin
      case (mode)
        0:       bv[d] = 1'b1;
        1: begin bv[d] = ph; ph = !ph; end
        default: bv[d] = 1'($urandom_range(0, 1));
      endcase
      // Mode 2 also throws illegal starts at the busy loader.
      if (mode == 2) begin
        st[d]   = ($urandom_range(0, 5) == 0);
        wcnt[d] = '0;
      end
      bd[d] = bytes[idx];
      acc   = bv[d] && br[d];
      if (acc && first_cyc < 0) first_cyc = cyc;
      @(negedge clk);
      g++;
      if (acc) idx++;
    end
    bv[d] = 1'b0;
    st[d] = 1'b0;
    if (idx < limit) check("feed_timeout", idx, limit);
  endtask

  task automatic wait_done(input int d, output int dcyc);
    int   g    = 0;
    logic prev = 1'b1;
    while (dn[d] !== 1'b1 && g < 3000) begin
      prev = prst[d];
      @(negedge clk);
      g++;
    end
    dcyc = cyc;
    if (dn[d] !== 1'b1) begin
      check("done_timeout", dn[d], 1);
    end else begin
      check("prst_before_done", prev, 1);
      check("prst_at_done", prst[d], 0);
    end
  endtask

  task automatic run_load(input int d, input int n, input logic [7:0] bytes[$],
                          input int mode, input string tag);
    int          base, fc, dc, nw;
    logic [31:0] w;
    base = wrs.size();
    do_start(d, n);
    check({tag, "_ready"}, br[d], 1);
    check({tag, "_busy"},  bsy[d], 1);
    check({tag, "_prst"},  prst[d], 1);
    check({tag, "_err0"},  err[d], 0);
    feed(d, bytes, mode, 4 * n, fc);
    wait_done(d, dc);
    nw = wrs.size() - base;
    check({tag, "_nwrites"}, nw, n);
    for (int i = 0; i < n && i < nw; i++) begin
      w = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
      check({tag, "_addr"}, wrs[base+i].addr, i);
      check({tag, "_data"}, wrs[base+i].data, w);
    end
    if (nw > 0) check({tag, "_hold"}, dc - wrs[$].c, RST_HOLD + 1);
    if (mode == 0) check({tag, "_latency"}, dc - fc, 5 * n + RST_HOLD);
    check({tag, "_err_end"}, err[d], 0);
  endtask

  task automatic check_reset_outs(input int d, input string tag);
    check({tag, "_ready"}, br[d], 0);
    check({tag, "_we"},    we[d], 0);
    check({tag, "_prst"},  prst[d], 1);
    check({tag, "_busy"},  bsy[d], 0);
    check({tag, "_done"},  dn[d], 0);
    check({tag, "_err"},   err[d], 0);
    check({tag, "_addr"},  get_addr(d), 0);
    check({tag, "_wdata"}, wd[d], 0);
  endtask

  initial begin
    logic [7:0] q[$];
    int         n, base;

    rst = 1'b1; st = '0; bv = '0; wcnt = '0; bd = '0;
    repeat (2) @(negedge clk);
    check_reset_outs(0, "rst0");
    check_reset_outs(1, "rst1");
    rst    = 1'b0;
    inv_en = 1'b1;

    // Zero-length request from IDLE.
    do_start(0, 0);
    check("wc0_err", err[0], 1);
    check("wc0_busy", bsy[0], 0);
    @(negedge clk);
    check("wc0_idle_ready", br[0], 0);
    check("wc0_idle_prst", prst[0], 1);

    q = '{8'h0a, 8'h00, 8'ha0, 8'he3, 8'h00, 8'h10, 8'ha0, 8'he1};
    run_load(0, 2, q, 0, "plan_valid_hi");
    run_load(0, 2, q, 1, "plan_toggle");

    // Oversized request while running: flag it, keep running.
    do_start(0, 1025);
    check("big_err", err[0], 1);
    check("big_done", dn[0], 1);
    check("big_busy", bsy[0], 0);

    check("rerun_prst_before", prst[0], 0);
    q = '{8'h1e, 8'h50, 8'h43, 8'he2};
    run_load(0, 1, q, 0, "rerun");

    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 6);
      q = {};
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
      run_load(0, n, q, (k == 0) ? 0 : 2, "rand");
    end

    // Reset after six bytes of a three-word load.
    q = {};
    for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
    base = wrs.size();
    do_start(0, 3);
    feed(0, q, 0, 6, n);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outs(0, "midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_nwrites", wrs.size() - base, 1);
    if (wrs.size() > base) begin
      check("midrst_addr0", wrs[base].addr, 0);
      check("midrst_data0", wrs[base].data, {q[3], q[2], q[1], q[0]});
    end
    check("midrst_idle_prst", prst[0], 1);

    // Small-address DUT: depth boundary.
    do_start(1, 5);
    check("aw2_wc5_err", err[1], 1);
    check("aw2_wc5_busy", bsy[1], 0);
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
    run_load(1, 4, q, 2, "aw2_full");
    check("aw2_last_addr", wrs[$].addr, 3);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
